cat_rec_monitor: RTL and testbench

CAT_REC_MONITOR -- requirements
Module: cat_rec_monitor

---
 rtl/cat_rec_monitor.sv | 191 +++++++++++++++++++
 tb/tb_cat_rec_monitor.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/cat_rec_monitor.sv
// cat_rec_monitor: passive checker for an APB-programmed CatRec block.
// Watches APB phases, times start->done runs and polices CatRecOut.
// Ports: clk, rst (async, active-low); APB observe PSEL/PENABLE/PWRITE/
//   PADDR/PWDATA; run observe start/done/CatRecOut; clr_err clears flags.
//   Outputs: sticky err_apb/err_timeout/err_result, cycle_cnt,
//   last_latency, coverage counters cov_xfers/cov_cats.
// Option: define CAT_REC_MON_COVER_EN to build the coverage counters;
//   otherwise they are tied to zero.
module cat_rec_monitor #(
    parameter int Amba_Word       = 24,
    parameter int Amba_Addr_Depth = 13,
    parameter int TIMEOUT_CYC     = 4096,
    parameter int CNT_W           = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       PSEL,
    input  logic                       PENABLE,
    input  logic                       PWRITE,
    input  logic [Amba_Addr_Depth-1:0] PADDR,
    input  logic [Amba_Word-1:0]       PWDATA,
    input  logic                       start,
    input  logic                       done,
    input  logic                       CatRecOut,
    input  logic                       clr_err,
    output logic                       err_apb,
    output logic                       err_timeout,
    output logic                       err_result,
    output logic [CNT_W-1:0]           cycle_cnt,
    output logic [CNT_W-1:0]           last_latency,
    output logic [CNT_W-1:0]           cov_xfers,
    output logic [CNT_W-1:0]           cov_cats
);

    // apb_q holds the bus phase observed in the previous cycle.
    typedef enum logic [1:0] {APB_IDLE, APB_SETUP, APB_ACCESS} apb_st_e;
    typedef enum logic {RUN_IDLE, RUN_BUSY} run_st_e;

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] LAT_LIMIT = CNT_W'(TIMEOUT_CYC - 1);

    apb_st_e apb_q, apb_d;
    run_st_e run_q, run_d;

    logic [Amba_Addr_Depth-1:0] addr_q;
    logic [Amba_Word-1:0]       data_q;
    logic                       wr_q;
    logic                       cap;
    logic                       apb_viol;
    logic                       tmo_viol;
    logic                       res_viol;
    logic                       done_dly_q;

    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic [CNT_W-1:0] lat_q, lat_d, lat_inc;
    logic [CNT_W-1:0] last_q, last_d;
    logic             eapb_q, eapb_d;
    logic             etmo_q, etmo_d;
    logic             eres_q, eres_d;

    always_comb begin
        apb_d    = APB_IDLE;
        apb_viol = 1'b0;
        cap      = 1'b0;
        unique case (apb_q)
            APB_SETUP: begin
                if (!PSEL) begin
                    apb_viol = 1'b1;
                end else if (PENABLE) begin
                    apb_d = APB_ACCESS;
                    if (PADDR != addr_q || PWRITE != wr_q ||
                        (wr_q && PWDATA != data_q))
                        apb_viol = 1'b1;
                end else begin
                    // back-to-back SETUP: take it as a fresh setup phase
                    apb_d = APB_SETUP;
                    cap   = 1'b1;
                end
            end
            default: begin
                if (PENABLE) begin
                    apb_viol = 1'b1;
                end else if (PSEL) begin
                    apb_d = APB_SETUP;
                    cap   = 1'b1;
                end
            end
        endcase
    end

    assign lat_inc = (lat_q == CNT_MAX) ? lat_q : lat_q + 1'b1;

    always_comb begin
        run_d    = run_q;
        lat_d    = lat_q;
        last_d   = last_q;
        tmo_viol = 1'b0;
        unique case (run_q)
            RUN_IDLE: begin
                if (start) begin
                    lat_d = '0;
                    if (done) last_d = CNT_W'(1);
                    else      run_d  = RUN_BUSY;
                end
            end
            RUN_BUSY: begin
                if (start) begin
                    lat_d = '0;
                end else if (done) begin
                    last_d = lat_inc;
                    run_d  = RUN_IDLE;
                end else if (lat_q >= LAT_LIMIT) begin
                    tmo_viol = 1'b1;
                    run_d    = RUN_IDLE;
                end else begin
                    lat_d = lat_inc;
                end
            end
        endcase
    end

    // CatRecOut is legal only on a done cycle or the one after it
    assign res_viol = CatRecOut & ~done & ~done_dly_q;

    // a new violation wins over a simultaneous clear
    assign eapb_d = apb_viol | (eapb_q & ~clr_err);
    assign etmo_d = tmo_viol | (etmo_q & ~clr_err);
    assign eres_d = res_viol | (eres_q & ~clr_err);
    assign cyc_d  = (cyc_q == CNT_MAX) ? cyc_q : cyc_q + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            apb_q      <= APB_IDLE;
            run_q      <= RUN_IDLE;
            addr_q     <= '0;
            data_q     <= '0;
            wr_q       <= 1'b0;
            done_dly_q <= 1'b0;
            cyc_q      <= '0;
            lat_q      <= '0;
            last_q     <= '0;
            eapb_q     <= 1'b0;
            etmo_q     <= 1'b0;
            eres_q     <= 1'b0;
        end else begin
            apb_q      <= apb_d;
            run_q      <= run_d;
            done_dly_q <= done;
            cyc_q      <= cyc_d;
            lat_q      <= lat_d;
            last_q     <= last_d;
            eapb_q     <= eapb_d;
            etmo_q     <= etmo_d;
            eres_q     <= eres_d;
            if (cap) begin
                addr_q <= PADDR;
                data_q <= PWDATA;
                wr_q   <= PWRITE;
            end
        end
    end

`ifdef CAT_REC_MON_COVER_EN
    logic [CNT_W-1:0] cxf_q, cca_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cxf_q <= '0;
            cca_q <= '0;
        end else begin
            if (apb_d == APB_ACCESS && cxf_q != CNT_MAX)
                cxf_q <= cxf_q + 1'b1;
            if (done && CatRecOut && cca_q != CNT_MAX)
                cca_q <= cca_q + 1'b1;
        end
    end

    assign cov_xfers = cxf_q;
    assign cov_cats  = cca_q;
`else
    assign cov_xfers = '0;
    assign cov_cats  = '0;
`endif

    assign err_apb      = eapb_q;
    assign err_timeout  = etmo_q;
    assign err_result   = eres_q;
    assign cycle_cnt    = cyc_q;
    assign last_latency = last_q;

endmodule

// File: tb/tb_cat_rec_monitor.sv
// tb_cat_rec_monitor: directed bench for cat_rec_monitor.
// Runs a default instance and a TIMEOUT_CYC=16 instance side by side.
module tb_cat_rec_monitor;

`ifdef CAT_REC_MON_COVER_EN
    localparam bit COV = 1'b1;
`else
    localparam bit COV = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        PSEL, PENABLE, PWRITE;
    logic [12:0] PADDR;
    logic [23:0] PWDATA;
    logic        start, done, CatRecOut, clr_err;

    logic        ea, et, er;
    logic [31:0] cyc, last, cxf, cca;
    logic        ea16, et16, er16;
    logic [31:0] cyc16, last16, cxf16, cca16;

    int n_chk;
    int n_fail;

    cat_rec_monitor dut (
        .clk(clk), .rst(rst),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA),
        .start(start), .done(done), .CatRecOut(CatRecOut),
        .clr_err(clr_err),
        .err_apb(ea), .err_timeout(et), .err_result(er),
        .cycle_cnt(cyc), .last_latency(last),
        .cov_xfers(cxf), .cov_cats(cca)
    );

    cat_rec_monitor #(.TIMEOUT_CYC(16)) dut16 (
        .clk(clk), .rst(rst),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA),
        .start(start), .done(done), .CatRecOut(CatRecOut),
        .clr_err(clr_err),
        .err_apb(ea16), .err_timeout(et16), .err_result(er16),
        .cycle_cnt(cyc16), .last_latency(last16),
        .cov_xfers(cxf16), .cov_cats(cca16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk = 0; n_fail = 0;
        rst = 1'b0;
        PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = '0; PWDATA = '0;
        start = 0; done = 0; CatRecOut = 0; clr_err = 0;
        #3;
        chk("rst_cyc", cyc, 0);
        chk("rst_last", last, 0);
        chk("rst_errs", {ea, et, er}, 3'b000);
        tick(2);
        rst = 1'b1;

        // idle after release
        tick(10);
        chk("idle_cyc", cyc, 10);
        chk("idle_errs", {ea, et, er}, 3'b000);
        chk("idle_errs16", {ea16, et16, er16}, 3'b000);

        // clean APB write
        PSEL = 1; PWRITE = 1; PADDR = 13'h020; PWDATA = 24'h123456;
        tick();
        PENABLE = 1;
        tick();
        PSEL = 0; PENABLE = 0;
        tick();
        chk("apb_ok", ea, 0);

        // address changed between SETUP and ACCESS
        PSEL = 1; PADDR = 13'h010;
        tick();
        PENABLE = 1; PADDR = 13'h011;
        tick();
        chk("apb_addr_chg", ea, 1);
        PSEL = 0; PENABLE = 0;
        tick(3);
        chk("apb_sticky", ea, 1);
        chk("cov_xfers", cxf, COV ? 2 : 0);
        clr_err = 1;
        tick();
        clr_err = 0;
        chk("apb_clr", ea, 0);

        // PENABLE with no setup
        PENABLE = 1;
        tick();
        PENABLE = 0;
        chk("apb_pen_idle", ea, 1);
        clr_err = 1;
        tick();
        clr_err = 0;

        // write data changed between SETUP and ACCESS
        PSEL = 1; PWRITE = 1; PADDR = 13'h004; PWDATA = 24'h000001;
        tick();
        PENABLE = 1; PWDATA = 24'h000002;
        tick();
        PSEL = 0; PENABLE = 0;
        chk("apb_data_chg", ea, 1);
        clr_err = 1;
        tick();
        clr_err = 0;

        // 37-cycle run with a valid result
        start = 1;
        tick();
        start = 0;
        tick(36);
        done = 1; CatRecOut = 1;
        tick();
        done = 0;
        chk("lat37", last, 37);
        chk("res_done", er, 0);
        tick();
        CatRecOut = 0;
        chk("res_after", er, 0);
        chk("cov_cats", cca, COV ? 1 : 0);

        // start and done together
        start = 1; done = 1;
        tick();
        start = 0; done = 0;
        chk("lat_zero", last, 1);

        // done while idle is ignored
        done = 1;
        tick();
        done = 0;
        chk("done_idle", last, 1);

        // restart mid-run
        start = 1;
        tick();
        start = 0;
        tick(5);
        start = 1;
        tick();
        start = 0;
        tick(9);
        done = 1;
        tick();
        done = 0;
        chk("restart_lat", last, 10);
        chk("restart_err", et, 0);

        // timeout on the 16-cycle instance
        do_reset();
        start = 1;
        tick();
        start = 0;
        tick(15);
        chk("tmo_early", et16, 0);
        tick();
        chk("tmo_hit", et16, 1);
        done = 1;
        tick();
        done = 0;
        chk("tmo_fsm_idle", last16, 0);
        chk("no_tmo_4096", et, 0);
        chk("lat17_4096", last, 17);

        // reset in the middle of a run
        start = 1;
        tick();
        start = 0;
        tick(5);
        rst = 0;
        #2;
        chk("mid_rst_last", last, 0);
        chk("mid_rst_err16", et16, 0);
        tick();
        rst = 1;
        tick(20);
        chk("post_rst_tmo", et16, 0);
        chk("post_rst_last", last, 0);
        chk("post_rst_cyc", cyc, 20);

        // stray result, then clear racing a new violation
        CatRecOut = 1;
        tick();
        chk("res_stray", er, 1);
        clr_err = 1;
        tick();
        chk("res_clr_race", er, 1);
        CatRecOut = 0;
        tick();
        clr_err = 0;
        chk("res_clr", er, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
